// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions for the SRAM slave: response codes, bus widths,
// write-channel state encoding and the address-region decoder.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HAVE_AW,
        HAVE_W,
        RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        REG_MEM,
        REG_ID,
        REG_BAD,
        REG_MISALIGN
    } region_t;

    // The full word index is compared, so no upper address bit can alias into the array.
    function automatic region_t decode_region(input logic [ADDR_W-1:0] addr,
                                              input int unsigned depth);
        logic [ADDR_W-1:0] idx;
        idx = {2'b00, addr[ADDR_W-1:2]};
        if (addr[1:0] != 2'b00) begin
            return REG_MISALIGN;
        end else if (idx < depth) begin
            return REG_MEM;
        end else if (idx == depth) begin
            return REG_ID;
        end else begin
            return REG_BAD;
        end
    endfunction

    function automatic resp_t write_resp(input region_t region);
        case (region)
            REG_MEM:      return RESP_OKAY;
            REG_ID:       return RESP_SLVERR;
            REG_MISALIGN: return RESP_SLVERR;
            default:      return RESP_DECERR;
        endcase
    endfunction

    function automatic resp_t read_resp(input region_t region);
        case (region)
            REG_MEM:      return RESP_OKAY;
            REG_ID:       return RESP_OKAY;
            REG_MISALIGN: return RESP_SLVERR;
            default:      return RESP_DECERR;
        endcase
    endfunction

endpackage

// File: rtl/sram_slave_mem.sv
// Scratch word array: one synchronous write port, one combinational read port,
// cleared asynchronously while ARESETN is low.
module sram_slave_mem
    import axi_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave fronting a DEPTH-word scratch SRAM plus a read-only ID word
// at word index DEPTH; write and read channels run independently.
module axi_lite_sram_slave
    import axi_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter logic [31:0] ID_VALUE = 32'h5A5A_0001
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP
);

    localparam int IDX_W = $clog2(DEPTH);

    wr_state_t         wr_state;
    wr_state_t         wr_state_nxt;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    resp_t             bresp_q;

    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    region_t           wr_region;
    logic              mem_we;

    logic              ar_hs;
    logic              r_hs;
    region_t           rd_region;
    logic [DATA_W-1:0] mem_rdata;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             rresp_q;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    assign AWREADY = ARESETN && ((wr_state == IDLE) || (wr_state == HAVE_W));
    assign WREADY  = ARESETN && ((wr_state == IDLE) || (wr_state == HAVE_AW));
    assign BVALID  = (wr_state == RESP);
    assign BRESP   = bresp_q;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign b_hs  = BVALID && BREADY;

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_nxt = RESP;
                end else if (aw_hs) begin
                    wr_state_nxt = HAVE_AW;
                end else if (w_hs) begin
                    wr_state_nxt = HAVE_W;
                end
            end
            HAVE_AW: begin
                if (w_hs) begin
                    wr_state_nxt = RESP;
                end
            end
            HAVE_W: begin
                if (aw_hs) begin
                    wr_state_nxt = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    wr_state_nxt = IDLE;
                end
            end
            default: wr_state_nxt = IDLE;
        endcase
    end

    // The completing handshake may still be on the bus, so take it live rather than from the latch.
    assign commit    = (wr_state_nxt == RESP) && (wr_state != RESP);
    assign wr_addr   = aw_hs ? AWADDR : aw_addr_q;
    assign wr_data   = w_hs ? WDATA : w_data_q;
    assign wr_region = decode_region(wr_addr, DEPTH);
    assign mem_we    = commit && (wr_region == REG_MEM);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state  <= IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_hs) begin
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_data_q <= WDATA;
            end
            if (commit) begin
                bresp_q <= write_resp(wr_region);
            end
        end
    end

    sram_slave_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .we      (mem_we),
        .waddr   (wr_addr[IDX_W+1:2]),
        .wdata   (wr_data),
        .raddr   (ARADDR[IDX_W+1:2]),
        .rdata   (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    // ARREADY stays low through the R handshake cycle, so reads never overlap.
    assign ARREADY = ARESETN && !rvalid_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    assign ar_hs     = ARVALID && ARREADY;
    assign r_hs      = rvalid_q && RREADY;
    assign rd_region = decode_region(ARADDR, DEPTH);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= read_resp(rd_region);
            case (rd_region)
                REG_MEM: rdata_q <= mem_rdata;
                REG_ID:  rdata_q <= ID_VALUE;
                default: rdata_q <= '0;
            endcase
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: doc/axi_lite_sram_slave.md
AXI_LITE_SRAM_SLAVE -- requirements
Module: axi_lite_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of 32-bit words in the scratch array (power of 2, 4..256).
REQ-002 SHALL have parameter ID_VALUE, default 32'h5A5A_0001: read-only value at word address DEPTH (byte address DEPTH*4).
REQ-003 Ports, one per line, name direction width meaning:
- ACLK in 1: single clock, all logic on rising edge.
- ARESETN in 1: asynchronous active-low reset.
- AWVALID in 1 / AWREADY out 1 / AWADDR in 32: write address channel.
- WVALID in 1 / WREADY out 1 / WDATA in 32: write data channel.
- BVALID out 1 / BREADY in 1 / BRESP out 2: write response channel.
- ARVALID in 1 / ARREADY out 1 / ARADDR in 32: read address channel.
- RVALID out 1 / RREADY in 1 / RDATA out 32 / RRESP out 2: read data channel.

Function
REQ-004 SHALL accept AW and W independently, in either order or the same cycle; AWREADY = no AW latched and BVALID low; WREADY = no W latched and BVALID low.
REQ-005 SHALL latch AWADDR on AW handshake and WDATA on W handshake; latched values SHALL be held until the B handshake.
REQ-006 Write state machine SHALL have states IDLE, HAVE_AW, HAVE_W, RESP; IDLE->HAVE_AW/HAVE_W on a single handshake; ->RESP when both are latched; RESP->IDLE on BVALID&&BREADY.
REQ-007 SHALL update the array and assert BVALID in the cycle after the later of the AW/W handshakes (latency 1), both handshakes in the same cycle included.
REQ-008 BVALID and BRESP SHALL stay stable until BREADY; one write outstanding at most.
REQ-009 Decode: AWADDR[1:0]!=0 -> SLVERR (2'b10), no write; word index < DEPTH -> OKAY (2'b00), write; index == DEPTH (ID) -> SLVERR, no write; index > DEPTH -> DECERR (2'b11), no write.
REQ-010 Read path SHALL be independent of write path: ARREADY = RVALID low; on AR handshake RVALID SHALL rise next cycle with RDATA/RRESP registered.
REQ-011 RVALID, RDATA, RRESP SHALL stay stable until RREADY; a new AR SHALL NOT be accepted in the cycle of the R handshake (ARREADY rises the cycle after).
REQ-012 Read decode: misaligned -> SLVERR, RDATA 0; index < DEPTH -> OKAY, array word; index == DEPTH -> OKAY, ID_VALUE; index > DEPTH -> DECERR, RDATA 0.
REQ-013 Read and write to the same word with AR handshake in the same cycle as the array update SHALL return the pre-write data.
REQ-014 Address bits above log2(DEPTH+1)+2 SHALL participate in decode (no aliasing; any nonzero upper bit -> DECERR).

Reset
REQ-015 On ARESETN low, asynchronously: BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, write FSM=IDLE, latches cleared, all array words=0.
REQ-016 AWREADY, WREADY, ARREADY SHALL be 0 while ARESETN low and 1 in the first cycle after release.
REQ-017 Reset mid-transaction SHALL drop any pending write (array unchanged by it) and any pending read response.

Structure
REQ-018 axi_pkg SHALL hold resp codes (RESP_OKAY, RESP_SLVERR, RESP_DECERR), ADDR_W=32, DATA_W=32 and the write-FSM state enum.
REQ-019 Array SHALL be a sub-module sram_slave_mem: DEPTH x 32, one sync write port, one async read port, async clear on ARESETN.

Verification
REQ-020 AW at 0x08 then W 0x12345678 two cycles later -> BVALID one cycle after W handshake, BRESP=0; read 0x08 -> RDATA=0x12345678, RRESP=0.
REQ-021 W 0xDEADBEEF first, AW 0x3C three cycles later, BREADY held low 5 cycles -> BVALID/BRESP stable 5 cycles, AWREADY/WREADY low throughout; read 0x3C -> 0xDEADBEEF.
REQ-022 Write 0x42 (misaligned) -> BRESP=2, array unchanged; write 0x40 (ID) -> BRESP=2; read 0x40 -> 0x5A5A0001 OKAY; read 0x1000 -> RRESP=3, RDATA=0.
REQ-023 Same-cycle AW+W to 0x04 data 0xA5A5A5A5 with AR to 0x04 on the update cycle -> RDATA=0 (old), next read -> 0xA5A5A5A5.
REQ-024 Reset asserted with write latched (HAVE_AW) and RVALID pending -> all VALIDs 0 immediately, after release all READYs 1, read of that address returns 0.
